// File: rtl/tft_sprite_renderer_pkg.sv
// tft_sprite_renderer_pkg: panel geometry, RGB565 colour tables and axis direction type.
package tft_pkg;
  localparam int SCREEN_W = 480;
  localparam int SCREEN_H = 272;
  localparam int BAR_W = 60;
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;
  typedef enum logic {INC = 1'b0, DEC = 1'b1} axis_dir_e;
  localparam rgb565_t BAR [8] = '{
    rgb565_t'(16'hFFFF), rgb565_t'(16'hFFE0), rgb565_t'(16'h07FF), rgb565_t'(16'h07E0),
    rgb565_t'(16'hF81F), rgb565_t'(16'hF800), rgb565_t'(16'h001F), rgb565_t'(16'h0000)
  };
  localparam rgb565_t PALETTE [4] = '{
    rgb565_t'(16'hF800), rgb565_t'(16'h07E0), rgb565_t'(16'h001F), rgb565_t'(16'hFFE0)
  };
endpackage

// File: rtl/tft_sprite_renderer_if.sv
// tft_sprite_renderer_if: timing-generator inputs and RGB565/sprite-position outputs of the renderer.
interface tft_sprite_renderer_if;
  logic [9:0] in_pixelx;
  logic [9:0] in_pixely;
  logic in_en;
  logic in_vsync;
  logic in_ssync;
  logic in_pause;
  logic [4:0] out_red;
  logic [5:0] out_green;
  logic [4:0] out_blue;
  logic [9:0] out_sprite_x;
  logic [9:0] out_sprite_y;
  modport master (
    output in_pixelx, in_pixely, in_en, in_vsync, in_ssync, in_pause,
    input out_red, out_green, out_blue, out_sprite_x, out_sprite_y
  );
  modport slave (
    input in_pixelx, in_pixely, in_en, in_vsync, in_ssync, in_pause,
    output out_red, out_green, out_blue, out_sprite_x, out_sprite_y
  );
endinterface

// File: rtl/tft_bounce_axis.sv
// tft_bounce_axis: one sprite axis bouncing between 0 and LIMIT, stepping SPEED per frame tick.
module tft_bounce_axis import tft_pkg::*; #(
  parameter int SPEED = 3,
  parameter int LIMIT = 432,
  parameter int INIT = 0
) (
  input logic in_9mhz_clk,
  input logic in_rst,
  input logic tick,
  input logic pause,
  output logic [9:0] pos,
  output axis_dir_e dir
);
  localparam logic [0:0] ST_INC = 1'b0;
  localparam logic [0:0] ST_DEC = 1'b1;
  logic [0:0] st;
  logic [10:0] nxt;
  logic under, over;
  // positions never exceed 1023 going up, so bit 10 set can only mean a negative result
  always_comb begin
    nxt = st == ST_INC ? {1'b0, pos} + 11'(SPEED) : {1'b0, pos} - 11'(SPEED);
    under = nxt[10];
    over = !nxt[10] && nxt > 11'(LIMIT);
  end
  always_ff @(posedge in_9mhz_clk) begin
    if (in_rst) begin
      pos <= 10'(INIT);
      st <= ST_INC;
    end else if (tick && !pause) begin
      pos <= under ? 10'd0 : over ? 10'(LIMIT) : nxt[9:0];
      st <= under || over ? ~st : st;
    end
  end
  assign dir = st == ST_DEC ? DEC : INC;
endmodule

// File: rtl/tft_sprite_renderer.sv
// tft_sprite_renderer: colour bars plus a bouncing sprite, 2-cycle pixel pipeline to RGB565.
// Define TFT_SPRITE_BORDER_EN to draw a white 1-pixel ring around the sprite.
module tft_sprite_renderer import tft_pkg::*; #(
  parameter int SPRITE_W = 48,
  parameter int SPRITE_H = 32,
  parameter int SPEED = 3,
  parameter int INIT_X = 0,
  parameter int INIT_Y = 0
) (
  input logic in_9mhz_clk,
  input logic in_rst,
  tft_sprite_renderer_if.slave bus
);
  logic vsync_d, ssync_d, tick;
  logic [1:0] idx;
  logic [9:0] sx, sy;
  logic [10:0] x, y, sxe, sye;
  logic on_c, in_c, en_d, on_d, in_d;
  logic [2:0] bar, bar_d;
  rgb565_t spr, rgb;
  assign tick = vsync_d && !bus.in_vsync;
  tft_bounce_axis #(.SPEED(SPEED), .LIMIT(SCREEN_W - SPRITE_W), .INIT(INIT_X)) u_x (
    .in_9mhz_clk, .in_rst, .tick, .pause(bus.in_pause), .pos(sx), .dir()
  );
  tft_bounce_axis #(.SPEED(SPEED), .LIMIT(SCREEN_H - SPRITE_H), .INIT(INIT_Y)) u_y (
    .in_9mhz_clk, .in_rst, .tick, .pause(bus.in_pause), .pos(sy), .dir()
  );
  always_comb begin
    x = {1'b0, bus.in_pixelx};
    y = {1'b0, bus.in_pixely};
    sxe = {1'b0, sx};
    sye = {1'b0, sy};
    on_c = x < 11'(SCREEN_W) && y < 11'(SCREEN_H);
    in_c = x >= sxe && x < sxe + 11'(SPRITE_W) && y >= sye && y < sye + 11'(SPRITE_H);
    bar = 3'd7;
    for (int i = 6; i >= 0; i--) if (x < 11'((i + 1) * BAR_W)) bar = 3'(i);
  end
  always_ff @(posedge in_9mhz_clk) begin
    if (in_rst) begin
      vsync_d <= 1'b0;
      ssync_d <= 1'b0;
      idx <= '0;
      en_d <= 1'b0;
      on_d <= 1'b0;
      in_d <= 1'b0;
      bar_d <= '0;
      rgb <= '0;
    end else begin
      vsync_d <= bus.in_vsync;
      ssync_d <= bus.in_ssync;
      idx <= idx + 2'(bus.in_ssync && !ssync_d);
      en_d <= bus.in_en;
      on_d <= on_c;
      in_d <= in_c;
      bar_d <= bar;
      rgb <= !en_d || !on_d ? '0 : in_d ? spr : BAR[bar_d];
    end
  end
`ifdef TFT_SPRITE_BORDER_EN
  logic edge_d;
  always_ff @(posedge in_9mhz_clk) begin
    if (in_rst) edge_d <= 1'b0;
    else edge_d <= x == sxe || x == sxe + 11'(SPRITE_W - 1) || y == sye || y == sye + 11'(SPRITE_H - 1);
  end
  assign spr = edge_d ? rgb565_t'(16'hFFFF) : PALETTE[idx];
`else
  assign spr = PALETTE[idx];
`endif
  assign bus.out_red = rgb.r;
  assign bus.out_green = rgb.g;
  assign bus.out_blue = rgb.b;
  assign bus.out_sprite_x = sx;
  assign bus.out_sprite_y = sy;
endmodule

// File: tb/tb_tft_sprite_renderer.sv
// tb_tft_sprite_renderer: directed checks of motion, palette, pixel pipeline and reset.
module tb_tft_sprite_renderer;
  import tft_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  tft_sprite_renderer_if bus ();
  tft_sprite_renderer dut (.in_9mhz_clk(clk), .in_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic frame();
    bus.in_vsync = 1'b0;
    cyc();
    bus.in_vsync = 1'b1;
    cyc();
  endtask
  task automatic spulse();
    bus.in_ssync = 1'b1;
    cyc();
    bus.in_ssync = 1'b0;
    cyc();
  endtask
  task automatic pix(input int px, input int py, input logic en);
    bus.in_pixelx = 10'(px);
    bus.in_pixely = 10'(py);
    bus.in_en = en;
  endtask
  function automatic logic [31:0] rgbv();
    return {16'h0, bus.out_red, bus.out_green, bus.out_blue};
  endfunction
  function automatic logic [31:0] pos();
    return {6'h0, bus.out_sprite_x, 6'h0, bus.out_sprite_y};
  endfunction
  function automatic logic [31:0] pt(input int px, input int py);
    return {6'h0, 10'(px), 6'h0, 10'(py)};
  endfunction
  initial begin
    pix(0, 0, 1'b0);
    bus.in_vsync = 1'b1;
    bus.in_ssync = 1'b0;
    bus.in_pause = 1'b0;
    cyc(2);
    chk("reset_rgb", rgbv(), 32'h0);
    chk("reset_pos", pos(), pt(0, 0));
    rst = 1'b0;
    pix(10, 10, 1'b1);
    cyc();
    chk("latency_1cyc", rgbv(), 32'h0);
    cyc();
    chk("sprite_pal0", rgbv(), 32'hF800);
    pix(10, 10, 1'b0);
    cyc(2);
    chk("en_low", rgbv(), 32'h0);
    pix(130, 200, 1'b1);
    cyc(2);
    chk("bar2_cyan", rgbv(), 32'h07FF);
    pix(500, 5, 1'b1);
    cyc(2);
    chk("offscreen_x", rgbv(), 32'h0);
    pix(10, 300, 1'b1);
    cyc(2);
    chk("offscreen_y", rgbv(), 32'h0);
    pix(10, 32, 1'b1);
    cyc(2);
    chk("bar0_below_sprite", rgbv(), 32'hFFFF);
    pix(419, 100, 1'b1);
    cyc(2);
    chk("bar6_blue", rgbv(), 32'h001F);
    pix(420, 100, 1'b1);
    cyc(2);
    chk("bar7_black", rgbv(), 32'h0);
    pix(0, 0, 1'b1);
    cyc(2);
`ifdef TFT_SPRITE_BORDER_EN
    chk("sprite_corner", rgbv(), 32'hFFFF);
`else
    chk("sprite_corner", rgbv(), 32'hF800);
`endif
    pix(10, 10, 1'b1);
    spulse();
    chk("pal1", rgbv(), 32'h07E0);
    spulse();
    spulse();
    chk("pal3", rgbv(), 32'hFFE0);
    spulse();
    chk("pal_wrap", rgbv(), 32'hF800);
    frame();
    chk("tick1", pos(), pt(3, 3));
    frame();
    chk("tick2", pos(), pt(6, 6));
    bus.in_vsync = 1'b0;
    cyc(4);
    bus.in_vsync = 1'b1;
    cyc();
    chk("vsync_held_low", pos(), pt(9, 9));
    bus.in_pause = 1'b1;
    frame();
    frame();
    chk("pause", pos(), pt(9, 9));
    bus.in_pause = 1'b0;
    bus.in_vsync = 1'b0;
    bus.in_ssync = 1'b1;
    cyc();
    bus.in_vsync = 1'b1;
    bus.in_ssync = 1'b0;
    cyc();
    chk("tick_with_ssync_pos", pos(), pt(12, 12));
    pix(20, 20, 1'b1);
    cyc(2);
    chk("tick_with_ssync_pal", rgbv(), 32'h07E0);
    repeat (139) frame();
    chk("tick143", pos(), pt(429, 54));
    frame();
    chk("reach_limit", pos(), pt(432, 51));
    chk("reach_no_toggle", 32'(dut.u_x.dir), 32'(INC));
    frame();
    chk("clamp_pos", pos(), pt(432, 48));
    chk("clamp_toggle", 32'(dut.u_x.dir), 32'(DEC));
    frame();
    chk("after_bounce", pos(), pt(429, 45));
    pix(10, 10, 1'b1);
    cyc(2);
    chk("pre_reset_bar0", rgbv(), 32'hFFFF);
    rst = 1'b1;
    cyc();
    chk("midreset_rgb", rgbv(), 32'h0);
    chk("midreset_pos", pos(), pt(0, 0));
    chk("midreset_dir", 32'(dut.u_x.dir), 32'(INC));
    rst = 1'b0;
    cyc(2);
    chk("post_reset_pal0", rgbv(), 32'hF800);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
